// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_arb_pkg : shared types and helpers for the FIFO push/pop schedulers
// Revision 1.0
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single-entry table.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_picker : first set request at or after a rotating pointer (combinational)
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int n_req = 4,
  parameter int iw    = idx_w(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [iw-1:0]    ptr,
  output logic [iw-1:0]    winner,
  output logic             any
);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    any    = |req;
    // Scan farthest offset first so the closest request to ptr overwrites last.
    for (int k = n_req - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n_req;
      if (req[idx]) begin
        winner = idx[iw-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_push_arbiter : round-robin burst arbiter feeding the push side of a FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int width     = 16,
  parameter int n_req     = 4,
  parameter int burst_len = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req_valid,
  input  logic [n_req*width-1:0]   req_data,
  output logic [n_req-1:0]         req_ready,
  output logic                     fifo_push,
  output logic [width-1:0]         fifo_din,
  input  logic                     fifo_full,
  output logic [$clog2(n_req)-1:0] grant_id,
  output logic                     busy
);

  localparam int             iw        = idx_w(n_req);
  localparam logic [iw-1:0]  last_idx  = iw'(n_req - 1);
  localparam logic [7:0]     burst_max = 8'(burst_len);

  arb_state_t    state_q, state_d;
  logic [iw-1:0] owner_q, owner_d;
  logic [iw-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;

  logic [iw-1:0] pick_winner;
  logic          pick_any;

  rr_picker #(
    .n_req (n_req),
    .iw    (iw)
  ) u_rr_picker (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    logic release_grant;
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    req_ready     = '0;
    fifo_push     = 1'b0;
    fifo_din      = '0;
    release_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d    = pick_winner;
          beat_cnt_d = 8'd0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        req_ready[owner_q] = !fifo_full;
        // A dropped valid releases even while the FIFO is full.
        if (!req_valid[owner_q]) begin
          release_grant = 1'b1;
        end else if (!fifo_full) begin
          fifo_push  = 1'b1;
          fifo_din   = req_data[int'(owner_q)*width +: width];
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q + 8'd1 == burst_max) begin
            release_grant = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_grant) begin
      state_d  = IDLE;
      rr_ptr_d = (owner_q == last_idx) ? '0 : owner_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_push_arbiter : directed self-checking bench for fifo_push_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fifo_push_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           fifo_full;

  logic [N-1:0]   req_ready,  req_ready_b1;
  logic           fifo_push,  fifo_push_b1;
  logic [W-1:0]   fifo_din,   fifo_din_b1;
  logic [1:0]     grant_id,   grant_id_b1;
  logic           busy,       busy_b1;

  int n_checks;
  int n_errors;

  fifo_push_arbiter #(.width(W), .n_req(N), .burst_len(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_push(fifo_push), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
  );

  fifo_push_arbiter #(.width(W), .n_req(N), .burst_len(1)) dut_b1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_b1), .fifo_push(fifo_push_b1), .fifo_din(fifo_din_b1),
    .fifo_full(fifo_full), .grant_id(grant_id_b1), .busy(busy_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [12:0] pat;
    int          k;
    logic        pushed;

    n_checks  = 0;
    n_errors  = 0;

    // Reset with every producer valid: all outputs stay zero.
    rst       = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'hF;
    req_data  = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    tick();
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_push",  32'(fifo_push), 32'h0);
    check_eq("rst_din",   32'(fifo_din),  32'h0);
    check_eq("rst_gid",   32'(grant_id),  32'h0);
    check_eq("rst_busy",  32'(busy),      32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", 32'(busy), 32'h0);
    tick();
    @(negedge clk);
    check_eq("first_grant_busy",  32'(busy),      32'h1);
    check_eq("first_grant_id",    32'(grant_id),  32'h0);
    check_eq("first_grant_ready", 32'(req_ready), 32'h1);

    // Single producer on index 2: 4 pushes, bubble, 4 pushes, bubble, 2 pushes.
    do_reset();
    pat = 13'b1101111011110;
    k   = 0;
    req_valid = 4'b0100;
    req_data[2*W +: W] = 16'hA000;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      pushed = fifo_push;
      check_eq($sformatf("single_push_c%0d", c), 32'(fifo_push), 32'(pat[c]));
      if (pat[c]) begin
        check_eq($sformatf("single_din_c%0d", c), 32'(fifo_din), 32'(16'hA000 + k));
        check_eq($sformatf("single_gid_c%0d", c), 32'(grant_id), 32'h2);
      end
      tick();
      if (pushed) begin
        k++;
        req_data[2*W +: W] = 16'(16'hA000 + k);
        if (k == 10) req_valid = '0;
      end
    end
    check_eq("single_total_words", 32'(k), 32'd10);

    // Round robin with burst_len 1: grant order 0,1,2,3,0 with a push every other cycle.
    do_reset();
    req_valid = 4'hF;
    req_data  = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq($sformatf("rr_push_c%0d", c), 32'(fifo_push_b1), 32'(c % 2));
      if (c % 2 == 1) begin
        check_eq($sformatf("rr_gid_c%0d", c),   32'(grant_id_b1),  32'(((c - 1) / 2) % 4));
        check_eq($sformatf("rr_din_c%0d", c),   32'(fifo_din_b1),  32'(16'hB000 + ((c - 1) / 2) % 4));
        check_eq($sformatf("rr_ready_c%0d", c), 32'(req_ready_b1), 32'(1 << (((c - 1) / 2) % 4)));
      end
      tick();
    end

    // Full stall after two words of producer 1; burst resumes at the same beat.
    do_reset();
    req_valid = 4'b0010;
    k = 0;
    req_data[1*W +: W] = 16'hC000;
    for (int c = 0; c < 11; c++) begin
      fifo_full = (c >= 3 && c <= 7);
      @(negedge clk);
      pushed = fifo_push;
      if (c >= 3 && c <= 7) begin
        check_eq($sformatf("stall_push_c%0d", c),  32'(fifo_push), 32'h0);
        check_eq($sformatf("stall_ready_c%0d", c), 32'(req_ready), 32'h0);
        check_eq($sformatf("stall_gid_c%0d", c),   32'(grant_id),  32'h1);
        check_eq($sformatf("stall_busy_c%0d", c),  32'(busy),      32'h1);
      end else if (c == 1 || c == 2 || c == 8 || c == 9) begin
        check_eq($sformatf("stall_xfer_c%0d", c), 32'(fifo_push), 32'h1);
        check_eq($sformatf("stall_din_c%0d", c),  32'(fifo_din),  32'(16'hC000 + k));
      end else if (c == 10) begin
        check_eq("stall_release_busy", 32'(busy),      32'h0);
        check_eq("stall_release_push", 32'(fifo_push), 32'h0);
      end
      tick();
      if (pushed) begin
        k++;
        req_data[1*W +: W] = 16'(16'hC000 + k);
      end
    end
    fifo_full = 1'b0;

    // Early release by owner 1; rr_ptr moves to 2 so producer 3 beats producer 0.
    do_reset();
    req_valid = 4'b1010;
    req_data  = {16'hD300, 16'h0000, 16'hD100, 16'hD0FF};
    tick();
    @(negedge clk);
    check_eq("early_w0_gid", 32'(grant_id), 32'h1);
    check_eq("early_w0_din", 32'(fifo_din), 32'hD100);
    tick();
    @(negedge clk);
    check_eq("early_w1_push", 32'(fifo_push), 32'h1);
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    check_eq("early_drop_push", 32'(fifo_push), 32'h0);
    check_eq("early_drop_busy", 32'(busy),      32'h1);
    tick();
    @(negedge clk);
    check_eq("early_idle_busy", 32'(busy), 32'h0);
    tick();
    @(negedge clk);
    check_eq("early_next_gid", 32'(grant_id), 32'h3);
    check_eq("early_next_din", 32'(fifo_din), 32'hD300);

    // Asynchronous reset mid-burst, then arbitration restarts from index 0.
    do_reset();
    req_valid = 4'b0100;
    req_data  = {16'h0000, 16'hE200, 16'hE100, 16'h0000};
    tick();
    @(negedge clk);
    check_eq("async_pre_push", 32'(fifo_push), 32'h1);
    check_eq("async_pre_gid",  32'(grant_id),  32'h2);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_busy",  32'(busy),      32'h0);
    check_eq("async_push",  32'(fifo_push), 32'h0);
    check_eq("async_din",   32'(fifo_din),  32'h0);
    check_eq("async_gid",   32'(grant_id),  32'h0);
    check_eq("async_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b1;
    req_valid = 4'b0110;
    tick();
    @(negedge clk);
    check_eq("async_restart_gid", 32'(grant_id), 32'h1);
    check_eq("async_restart_din", 32'(fifo_din), 32'hE100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the push side of one `fifo_flops` instance between `n_req` producers. Each producer offers words on a valid/ready handshake; the arbiter grants one owner at a time for a bounded burst and drives `push`/`Din` of the FIFO while honouring `full`. It sits directly in front of `fifo_flops`. The pop side (`pop`, `Dout`, `pndng`) is left to the consumer.

## Interface
- `width`, 16: data width; must match the `bits` parameter of `fifo_flops`.
- `n_req`, 4: number of producers, 2..16.
- `burst_len`, 4: maximum words per grant, 1..255.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  n_req  producer i has a word.
- `req_data`  in  n_req×width  producer words, packed, producer i at `[i*width +: width]`.
- `req_ready`  out  n_req  producer i's word is taken this cycle.
- `fifo_push`  out  1  to `fifo_flops.push`.
- `fifo_din`  out  width  to `fifo_flops.Din`.
- `fifo_full`  in  1  from `fifo_flops.full`.
- `grant_id`  out  $clog2(n_req)  current owner index, registered.
- `busy`  out  1  state is GRANT.

## Operation
- States: IDLE and GRANT. Registers: `state`, `owner`, `rr_ptr`, `beat_cnt` (8 bit).
- IDLE: if any `req_valid` is set, pick the first set bit at or after `rr_ptr`, wrapping modulo `n_req`. Then `owner`←winner, `beat_cnt`←0, and the state goes to GRANT. No transfer happens in IDLE. `fifo_full` does not block arbitration.
- GRANT: `req_ready[owner]` = `!fifo_full`. All other `req_ready` bits are 0.
- Transfer condition: `req_valid[owner] && req_ready[owner]`. On a transfer, `fifo_push`=1, `fifo_din`=`req_data[owner]`, and `beat_cnt`+1.
- When there is no transfer, `fifo_push`=0 and `fifo_din`=0.
- Release the grant, with `rr_ptr`←(owner+1) mod `n_req` and the state going to IDLE, when either:
  - a transfer brings `beat_cnt`+1 to `burst_len`, or
  - `req_valid[owner]`=0 in GRANT. No transfer happens that cycle.
- `fifo_full`=1 in GRANT: stall. Grant, `beat_cnt` and `rr_ptr` are held. A full condition never forces a release.
- A requester deasserting valid while full is treated as a release; valid low always takes priority.
- Non-owner valid bits are ignored in GRANT. Producers keep their data stable until ready.
- Reset mid-burst: the burst is discarded. The FIFO shares `rst`, so no partial state remains.

## Timing
- Reset values: `state`=IDLE, `owner`=0, `rr_ptr`=0, `beat_cnt`=0. Outputs: `req_ready`=0, `fifo_push`=0, `fifo_din`=0, `grant_id`=0, `busy`=0.
- Arbitration latency: 1 cycle. Valid seen in IDLE at cycle t gives the first possible transfer at t+1.
- `req_ready`, `fifo_push` and `fifo_din` are combinational from registered state, `fifo_full` and `req_valid`/`req_data`. There are no combinational loops with the FIFO.
- Throughput: 1 word/cycle within a burst. Each grant costs one bubble, so the sustained rate is `burst_len`/(`burst_len`+1).
- `fifo_push` is never 1 in a cycle where `fifo_full`=1. This guarantees no overflow.
- Fairness bound: a continuously valid producer waits at most (n_req−1)×(burst_len+1) cycles for a grant.

## Structure
- Package `fifo_arb_pkg` contains:
  - the state enum `arb_state_t` {IDLE, GRANT};
  - the function `idx_w(n)` = max(1, $clog2(n)).
- Sub-module `rr_picker`: combinational. Inputs are the request vector and `rr_ptr`. Outputs are `winner` and `any`. It is reused by the pop-side scheduler.
- The top instantiates `rr_picker` and holds the FSM and counters.

## Test plan
- Reset: `rst`=0 with all `req_valid`=1 → every output is 0. After release, IDLE → owner 0 is granted on the next edge.
- Single producer: `req_valid[2]`=1 with data 0xA000..0xA009, `burst_len`=4 → pattern of 4 pushes, 1 bubble, 4 pushes, 1 bubble, 2 pushes. The FIFO receives the words in order.
- Round-robin: all 4 valid continuously, `burst_len`=1 → grant order 0,1,2,3,0… A push occurs every other cycle.
- Full stall: `fifo_full` forced high mid-burst for 5 cycles → `fifo_push`=0 and `req_ready`=0 throughout, owner unchanged. The burst resumes at the same `beat_cnt`.
- Early release: owner 1 drops valid after 2 words → IDLE on the next cycle, `rr_ptr`=2. Producer 3, valid, wins next.
- Async reset mid-burst: `rst` low between edges → outputs go to 0 immediately. After release, arbitration restarts from index 0.
